// File: rtl/instr_seq_ctrl_if.sv
// Memory bus bundle between the multi-cycle sequencer and the shared
// instruction/data memory. The core side drives the strobes and the address
// source select; the memory side returns stall and read data.
interface instr_seq_ctrl_if;
    logic        mem_read;
    logic        mem_write;
    logic        addr_sel;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;

    modport master (
        output mem_read,
        output mem_write,
        output addr_sel,
        input  mem_waitrequest,
        input  mem_readdata
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  addr_sel,
        output mem_waitrequest,
        output mem_readdata
    );
endinterface

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for the MIPS datapath.
// Latches the instruction register, registers the immediate-form and
// destination selects, drives the memory strobes, gates register-file writes
// and PC advance, and halts the core once execution reaches address 0.
module instr_seq_ctrl (
    input  logic              clk,
    input  logic              reset_n,
    instr_seq_ctrl_if.master  bus,
    input  logic              pc_zero,
    output logic [31:0]       instr,
    output logic [1:0]        imm_sel,
    output logic [1:0]        dst_sel,
    output logic              regfile_we,
    output logic              pc_advance,
    output logic              active
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    // r_armed is clear for the single cycle after reset: FETCH evaluates
    // pc_zero there but keeps the bus idle, so the first strobe appears one
    // cycle after reset_n rises. It stays set until the next reset.
    logic [1:0]  r_state;
    logic        r_armed;
    logic [31:0] r_instr;
    logic [1:0]  r_imm_sel;
    logic [1:0]  r_dst_sel;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_writes;
    logic        w_done;
    logic [1:0]  w_imm_dec;
    logic [1:0]  w_dst_dec;

    assign w_op    = r_instr[31:26];
    assign w_funct = r_instr[5:0];

    // Instruction class decode from the latched instruction register.
    always_comb begin
        w_is_load  = (w_op >= 6'h20) && (w_op <= 6'h26);
        w_is_store = (w_op == 6'h28) || (w_op == 6'h29) || (w_op == 6'h2B);
        w_is_mem   = w_is_load || w_is_store;

        w_writes = 1'b0;
        if (w_op == 6'h00) begin
            // JR, MTHI, MTLO, MULT(U), DIV(U) leave the GPR file untouched
            case (w_funct)
                6'h08, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: w_writes = 1'b0;
                default:                                          w_writes = 1'b1;
            endcase
        end else if ((w_op >= 6'h08) && (w_op <= 6'h0F)) begin
            w_writes = 1'b1;
        end else if (w_is_load || (w_op == 6'h03)) begin
            w_writes = 1'b1;
        end

        w_imm_dec = 2'd0;
        case (w_op)
            6'h0C, 6'h0D, 6'h0E: w_imm_dec = 2'd1;
            6'h0F:               w_imm_dec = 2'd2;
            default:             w_imm_dec = 2'd0;
        endcase

        w_dst_dec = 2'd1;
        case (w_op)
            6'h00:   w_dst_dec = 2'd0;
            6'h03:   w_dst_dec = 2'd2;
            default: w_dst_dec = 2'd1;
        endcase
    end

    // A memory EXEC completes on its first non-stalled cycle; everything
    // else completes in its single EXEC cycle regardless of waitrequest.
    assign w_done = (r_state == S_EXEC) && (!w_is_mem || !bus.mem_waitrequest);

    // Sequencer state, instruction register and registered selects.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_armed   <= 1'b0;
            r_instr   <= 32'h0000_0000;
            r_imm_sel <= 2'd0;
            r_dst_sel <= 2'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (pc_zero) begin
                        r_state <= S_HALT;
                    end else if (!r_armed) begin
                        r_armed <= 1'b1;
                    end else if (!bus.mem_waitrequest) begin
                        r_instr <= bus.mem_readdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_imm_sel <= w_imm_dec;
                    r_dst_sel <= w_dst_dec;
                    r_state   <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_done) begin
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    // Bus strobes: a fetch is suppressed outright when the PC is zero, so the
    // halting FETCH cycle never touches the bus. Read and write are exclusive
    // because an instruction is never both a load and a store.
    always_comb begin
        bus.mem_read  = ((r_state == S_FETCH) && r_armed && !pc_zero) ||
                        ((r_state == S_EXEC) && w_is_load);
        bus.mem_write = (r_state == S_EXEC) && w_is_store;
        bus.addr_sel  = (r_state == S_EXEC) && w_is_mem;
    end

    assign regfile_we = w_done && w_writes;
    assign pc_advance = w_done;
    assign active     = (r_state != S_HALT);
    assign instr      = r_instr;
    assign imm_sel    = r_imm_sel;
    assign dst_sel    = r_dst_sel;

endmodule
